// File: rtl/traj_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traj_pkg: shared point type, default colour and fade helper. Rev 1.0
// ----------------------------------------------------------------------------
package traj_pkg;

  localparam int          DEF_H_WIDTH       = 11;
  localparam int          DEF_V_WIDTH       = 10;
  localparam logic [23:0] DEFAULT_DOT_COLOR = 24'h00FF00;
  localparam logic [23:0] MIN_OPAQUE_COLOR  = 24'h010101;

  typedef struct packed {
    logic [DEF_H_WIDTH-1:0] x;
    logic [DEF_V_WIDTH-1:0] y;
  } point_t;

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    PENDING = 1'b1
  } wr_state_t;

  // Later points are dimmer; a fully faded colour must stay non-transparent.
  function automatic logic [23:0] fade_color(input logic [23:0] color,
                                             input int idx,
                                             input int num_points);
    int          shift;
    logic [23:0] faded;
    shift = (idx * 4) / num_points;
    faded = {color[23:16] >> shift, color[15:8] >> shift, color[7:0] >> shift};
    if (faded == 24'd0) faded = MIN_OPAQUE_COLOR;
    return faded;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trajectory_renderer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trajectory_renderer_if: point-list valid/ready stream. Rev 1.0
// ----------------------------------------------------------------------------
interface trajectory_renderer_if import traj_pkg::*; #(
  parameter int H_WIDTH = DEF_H_WIDTH,
  parameter int V_WIDTH = DEF_V_WIDTH
) ();

  logic               pt_valid_in;
  logic               pt_ready_out;
  logic [H_WIDTH-1:0] pt_x_in;
  logic [V_WIDTH-1:0] pt_y_in;
  logic               pt_last_in;

  modport master (
    output pt_valid_in, pt_x_in, pt_y_in, pt_last_in,
    input  pt_ready_out
  );

  modport slave (
    input  pt_valid_in, pt_x_in, pt_y_in, pt_last_in,
    output pt_ready_out
  );

endinterface
`default_nettype wire

// File: rtl/traj_point_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traj_point_bank: two point banks; writes go to the back, reads from the front. Rev 1.0
// ----------------------------------------------------------------------------
module traj_point_bank #(
  parameter  int NUM_POINTS = 16,
  parameter  int H_WIDTH    = 11,
  parameter  int V_WIDTH    = 10,
  localparam int IDX_W      = $clog2(NUM_POINTS),
  localparam int CNT_W      = $clog2(NUM_POINTS) + 1
) (
  input  wire                                   clk_in,
  input  wire                                   rst_in,
  input  wire                                   wr_en,
  input  wire  [IDX_W-1:0]                      wr_idx,
  input  wire  [H_WIDTH-1:0]                    wr_x,
  input  wire  [V_WIDTH-1:0]                    wr_y,
  input  wire                                   count_en,
  input  wire  [CNT_W-1:0]                      count_val,
  input  wire                                   swap,
  output logic [NUM_POINTS-1:0][H_WIDTH-1:0]    front_x,
  output logic [NUM_POINTS-1:0][V_WIDTH-1:0]    front_y,
  output logic [CNT_W-1:0]                      front_count
);

  logic [1:0][NUM_POINTS-1:0][H_WIDTH-1:0] mem_x;
  logic [1:0][NUM_POINTS-1:0][V_WIDTH-1:0] mem_y;
  logic [1:0][CNT_W-1:0]                   count;
  logic                                    front_sel;
  logic                                    back_sel;

  assign back_sel = ~front_sel;

  // Coordinates need no reset: a zero count masks every stale entry.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_x[back_sel][wr_idx] <= wr_x;
      mem_y[back_sel][wr_idx] <= wr_y;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count     <= '0;
      front_sel <= 1'b0;
    end else begin
      if (count_en) count[back_sel] <= count_val;
      if (swap)     front_sel       <= ~front_sel;
    end
  end

  assign front_x     = mem_x[front_sel];
  assign front_y     = mem_y[front_sel];
  assign front_count = count[front_sel];

endmodule
`default_nettype wire

// File: rtl/trajectory_renderer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trajectory_renderer: point list -> 2-cycle per-pixel overlay colour. Rev 1.0
// Optional TRAJ_FADE_EN: later points drawn dimmer.
// ----------------------------------------------------------------------------
module trajectory_renderer import traj_pkg::*; #(
  parameter int          NUM_POINTS = 16,
  parameter int          H_WIDTH    = DEF_H_WIDTH,
  parameter int          V_WIDTH    = DEF_V_WIDTH,
  parameter int          RADIUS     = 2,
  parameter logic [23:0] DOT_COLOR  = DEFAULT_DOT_COLOR
) (
  input  wire                  clk_in,
  input  wire                  rst_in,
  trajectory_renderer_if.slave pt,
  input  wire  [H_WIDTH-1:0]   hcount_in,
  input  wire  [V_WIDTH-1:0]   vcount_in,
  input  wire                  scan_valid_in,
  input  wire                  new_frame_in,
  output logic [23:0]          trajectory_pixel_out,
  output logic                 pixel_valid_out,
  output logic                 overflow_out
);

  localparam int IDX_W = $clog2(NUM_POINTS);
  localparam int CNT_W = $clog2(NUM_POINTS) + 1;
  localparam logic signed [H_WIDTH:0] RAD_H = RADIUS[H_WIDTH:0];
  localparam logic signed [V_WIDTH:0] RAD_V = RADIUS[V_WIDTH:0];

  wr_state_t        state, state_nxt;
  logic             ready, accept, wr_en, count_en, swap;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] count_val;
  logic             list_full;

  logic [NUM_POINTS-1:0][H_WIDTH-1:0] front_x;
  logic [NUM_POINTS-1:0][V_WIDTH-1:0] front_y;
  logic [CNT_W-1:0]                   front_count;

  assign list_full       = (wr_idx == CNT_W'(NUM_POINTS));
  assign count_val       = list_full ? CNT_W'(NUM_POINTS) : wr_idx + CNT_W'(1);
  assign pt.pt_ready_out = ready;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= FILL;
    else         state <= state_nxt;
  end

  // A new_frame pulse only swaps from PENDING, so a list closing in the same
  // cycle waits for the following frame.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    wr_en     = 1'b0;
    count_en  = 1'b0;
    swap      = 1'b0;
    case (state)
      FILL: begin
        ready = 1'b1;
        if (pt.pt_valid_in) begin
          accept = 1'b1;
          wr_en  = !list_full;
          if (pt.pt_last_in) begin
            count_en  = 1'b1;
            state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        if (new_frame_in) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_idx       <= '0;
      overflow_out <= 1'b0;
    end else if (accept) begin
      if (list_full)          overflow_out <= 1'b1;
      if (pt.pt_last_in)      wr_idx       <= '0;
      else if (!list_full)    wr_idx       <= wr_idx + CNT_W'(1);
    end
  end

  traj_point_bank #(
    .NUM_POINTS (NUM_POINTS),
    .H_WIDTH    (H_WIDTH),
    .V_WIDTH    (V_WIDTH)
  ) u_bank (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx[IDX_W-1:0]),
    .wr_x        (pt.pt_x_in),
    .wr_y        (pt.pt_y_in),
    .count_en    (count_en),
    .count_val   (count_val),
    .swap        (swap),
    .front_x     (front_x),
    .front_y     (front_y),
    .front_count (front_count)
  );

  logic [NUM_POINTS-1:0]       hit_d, hit_q;
  logic [NUM_POINTS-1:0][23:0] point_color;
  logic [23:0]                 pix_d;
  logic                        s1_valid;

  // One extra sign bit keeps differences from wrapping at the screen edges.
  for (genvar i = 0; i < NUM_POINTS; i++) begin : g_hit
    logic signed [H_WIDTH:0] dx;
    logic signed [V_WIDTH:0] dy;
    assign dx = $signed({1'b0, hcount_in}) - $signed({1'b0, front_x[i]});
    assign dy = $signed({1'b0, vcount_in}) - $signed({1'b0, front_y[i]});
    assign hit_d[i] = (CNT_W'(i) < front_count) &&
                      (dx <= RAD_H) && (dx >= -RAD_H) &&
                      (dy <= RAD_V) && (dy >= -RAD_V);
  end

  for (genvar i = 0; i < NUM_POINTS; i++) begin : g_color
`ifdef TRAJ_FADE_EN
    assign point_color[i] = fade_color(DOT_COLOR, i, NUM_POINTS);
`else
    assign point_color[i] = DOT_COLOR;
`endif
  end

  always_comb begin
    pix_d = 24'd0;
    for (int i = NUM_POINTS - 1; i >= 0; i--) begin
      if (hit_q[i]) pix_d = point_color[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hit_q                <= '0;
      s1_valid             <= 1'b0;
      trajectory_pixel_out <= 24'd0;
      pixel_valid_out      <= 1'b0;
    end else begin
      hit_q                <= hit_d;
      s1_valid             <= scan_valid_in;
      trajectory_pixel_out <= s1_valid ? pix_d : 24'd0;
      pixel_valid_out      <= s1_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trajectory_renderer.sv
`default_nettype none
// tb_trajectory_renderer: table probes and scoreboarded scans checked against a point-list model.
module tb_trajectory_renderer;
  import traj_pkg::*;

  localparam int          NP  = 16;
  localparam int          HW  = 11;
  localparam int          VW  = 10;
  localparam int          RAD = 2;
  localparam logic [23:0] DOT = 24'h00FF00;
`ifdef TRAJ_FADE_EN
  localparam logic [23:0] FADE_LO = 24'h001F00;
`else
  localparam logic [23:0] FADE_LO = 24'h00FF00;
`endif

  logic          clk_in        = 1'b0;
  logic          rst_in        = 1'b0;
  logic [HW-1:0] hcount_in     = '0;
  logic [VW-1:0] vcount_in     = '0;
  logic          scan_valid_in = 1'b0;
  logic          new_frame_in  = 1'b0;
  logic [23:0]   trajectory_pixel_out;
  logic          pixel_valid_out;
  logic          overflow_out;

  trajectory_renderer_if #(.H_WIDTH(HW), .V_WIDTH(VW)) pt_if ();

  trajectory_renderer #(
    .NUM_POINTS (NP),
    .H_WIDTH    (HW),
    .V_WIDTH    (VW),
    .RADIUS     (RAD),
    .DOT_COLOR  (DOT)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .pt                   (pt_if),
    .hcount_in            (hcount_in),
    .vcount_in            (vcount_in),
    .scan_valid_in        (scan_valid_in),
    .new_frame_in         (new_frame_in),
    .trajectory_pixel_out (trajectory_pixel_out),
    .pixel_valid_out      (pixel_valid_out),
    .overflow_out         (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {logic [23:0] pix; int issue;} exp_t;
  typedef struct {int scen; int h; int v; logic [23:0] exp;} probe_t;

  exp_t   sbq[$];
  probe_t tbl[$];
  point_t front_q[$], back_q[$], build_q[$];
  bit     pending = 0;
  bit     mon_en  = 0;
  int     total   = 0;
  int     bad     = 0;
  int     cyc     = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [23:0] color_of(input int i);
`ifdef TRAJ_FADE_EN
    int          sh = (i * 4) / NP;
    logic [23:0] c;
    c = {DOT[23:16] >> sh, DOT[15:8] >> sh, DOT[7:0] >> sh};
    return (c == 24'd0) ? 24'h010101 : c;
`else
    return DOT;
`endif
  endfunction

  function automatic logic [23:0] exp_pixel(input int h, input int v);
    for (int i = 0; i < front_q.size(); i++) begin
      int dx = h - int'(front_q[i].x);
      int dy = v - int'(front_q[i].y);
      if (dx <= RAD && dx >= -RAD && dy <= RAD && dy >= -RAD) return color_of(i);
    end
    return 24'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (mon_en) begin
      if (pixel_valid_out) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pix_unexpected: got pixel_valid=1 expected 0 (nothing in flight)");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("pixel", trajectory_pixel_out, e.pix);
          check("latency", cyc - e.issue, 2);
        end
      end else begin
        check("pix_idle", trajectory_pixel_out, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic scan(input int h, input int v, input logic [23:0] e);
    hcount_in     = h[HW-1:0];
    vcount_in     = v[VW-1:0];
    scan_valid_in = 1'b1;
    sbq.push_back('{e, cyc});
    tick();
    scan_valid_in = 1'b0;
  endtask

  task automatic drain();
    scan_valid_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic scan_row(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      if (h % 9 == 8) tick();
      scan(h, v, exp_pixel(h, v));
    end
    drain();
  endtask

  task automatic run_table(input int scen);
    for (int k = 0; k < tbl.size(); k++)
      if (tbl[k].scen == scen) scan(tbl[k].h, tbl[k].v, tbl[k].exp);
    drain();
  endtask

  task automatic send_point(input int x, input int y, input bit last);
    int     n = 0;
    point_t p;
    pt_if.pt_valid_in = 1'b1;
    pt_if.pt_x_in     = x[HW-1:0];
    pt_if.pt_y_in     = y[VW-1:0];
    pt_if.pt_last_in  = last;
    while (!pt_if.pt_ready_out && n < 50) begin
      tick();
      n++;
    end
    if (!pt_if.pt_ready_out) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 expected 1");
    end
    tick();
    pt_if.pt_valid_in = 1'b0;
    pt_if.pt_last_in  = 1'b0;
    p.x = x[HW-1:0];
    p.y = y[VW-1:0];
    if (build_q.size() < NP) build_q.push_back(p);
    if (last) begin
      back_q = build_q;
      build_q.delete();
      pending = 1;
    end
  endtask

  task automatic swap_frame();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
    if (pending) begin
      front_q = back_q;
      pending = 0;
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    repeat (3) tick();
    check("rst_ready", pt_if.pt_ready_out, 1);
    check("rst_pixel", trajectory_pixel_out, 0);
    check("rst_pvalid", pixel_valid_out, 0);
    check("rst_overflow", overflow_out, 0);
    rst_in = 1'b1;
    front_q.delete();
    back_q.delete();
    build_q.delete();
    pending = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // scen 1: single point (100,50)
    tbl.push_back('{1,  98, 50, DOT});  tbl.push_back('{1, 102, 50, DOT});
    tbl.push_back('{1,  97, 50, 0});    tbl.push_back('{1, 103, 50, 0});
    tbl.push_back('{1, 100, 48, DOT});  tbl.push_back('{1, 100, 52, DOT});
    tbl.push_back('{1, 100, 47, 0});    tbl.push_back('{1, 100, 53, 0});
    tbl.push_back('{1,  99, 49, DOT});  tbl.push_back('{1, 101, 51, DOT});
    // scen 2: screen corners (0,0) and (639,479)
    tbl.push_back('{2,   0,   0, DOT}); tbl.push_back('{2,   2,   0, DOT});
    tbl.push_back('{2,   3,   0, 0});   tbl.push_back('{2,   0,   2, DOT});
    tbl.push_back('{2,   0,   3, 0});   tbl.push_back('{2,   2,   2, DOT});
    tbl.push_back('{2, 637,   0, 0});   tbl.push_back('{2, 639,   0, 0});
    tbl.push_back('{2,2047,   0, 0});   tbl.push_back('{2,   0,1023, 0});
    tbl.push_back('{2, 639, 479, DOT}); tbl.push_back('{2, 637, 477, DOT});
    tbl.push_back('{2, 636, 479, 0});
    // scen 3: 20-point list, only the first 16 kept
    tbl.push_back('{3, 200, 300, DOT}); tbl.push_back('{3, 350, 300, FADE_LO});
    tbl.push_back('{3, 360, 300, 0});   tbl.push_back('{3, 390, 300, 0});
    // scen 4: index 0 at (50,60) overlapping index 12 at (53,60)
    tbl.push_back('{4,  51, 60, DOT});  tbl.push_back('{4,  52, 60, DOT});
    tbl.push_back('{4,  48, 60, DOT});  tbl.push_back('{4,  55, 60, FADE_LO});
    tbl.push_back('{4,  53, 62, FADE_LO}); tbl.push_back('{4, 56, 60, 0});
    tbl.push_back('{4,  51, 62, DOT});

    pt_if.pt_valid_in = 1'b0;
    pt_if.pt_x_in     = '0;
    pt_if.pt_y_in     = '0;
    pt_if.pt_last_in  = 1'b0;

    do_reset();
    mon_en = 1;

    // Nothing written yet: whole line transparent.
    scan_row(10, 0, 639);

    send_point(100, 50, 1);
    check("pending_ready", pt_if.pt_ready_out, 0);
    swap_frame();
    check("fill_ready", pt_if.pt_ready_out, 1);
    run_table(1);
    scan_row(50, 90, 110);

    send_point(0, 0, 0);
    send_point(639, 479, 1);
    swap_frame();
    run_table(2);
    scan_row(0, 0, 639);

    for (int i = 0; i < 16; i++) send_point(200 + 10 * i, 300, 0);
    check("ovf_at_16", overflow_out, 0);
    send_point(360, 300, 0);
    check("ovf_at_17", overflow_out, 1);
    for (int i = 17; i < 20; i++) send_point(200 + 10 * i, 300, i == 19);
    swap_frame();
    run_table(3);
    scan_row(300, 190, 400);
    repeat (10) tick();
    check("ovf_sticky", overflow_out, 1);
    do_reset();
    scan(200, 300, 0);
    drain();

    // List closes in the same cycle as new_frame: no swap until the next pulse.
    send_point(100, 50, 1);
    swap_frame();
    new_frame_in = 1'b1;
    send_point(300, 200, 1);
    new_frame_in = 1'b0;
    check("same_cyc_ready", pt_if.pt_ready_out, 0);
    scan(100, 50, DOT);
    scan(300, 200, 0);
    drain();
    repeat (5) tick();
    check("same_cyc_hold", pt_if.pt_ready_out, 0);
    swap_frame();
    check("same_cyc_swap", pt_if.pt_ready_out, 1);
    scan(300, 200, DOT);
    scan(100, 50, 0);
    drain();

    send_point(50, 60, 0);
    for (int i = 1; i < 12; i++) send_point(1000 + 4 * i, 900, 0);
    send_point(53, 60, 1);
    swap_frame();
    run_table(4);

    drain();
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
